// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch driver.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    REDIRECT = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } fetch_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0] ERR_CMISMATCH = 2'd2;

  localparam int unsigned ILEN_C = 2;
  localparam int unsigned ILEN_N = 4;
  localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/fetch_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles without a kick.
// expired is a same-cycle flag so the owner can react on the TIMEOUT-th stall.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !kick && (cnt == LAST);

  // Stall counter; cleared whenever disabled or kicked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || kick) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_driver.sv
// Instruction-fetch driver: PC stream generation, retire, periodic redirects,
// compressed-flag check and stall watchdog.
// Optional: define FETCH_DRIVER_TRACE_EN to print a retire/redirect/terminal trace.
module fetch_driver
  import fetch_pkg::*;
#(
  parameter int unsigned       PC_W           = 64,
  parameter logic [PC_W-1:0]   RESET_PC       = '0,
  parameter int unsigned       MAX_INSTS      = 256,
  parameter int unsigned       REDIRECT_EVERY = 16,
  parameter longint            REDIRECT_OFF   = 'h40,
  parameter int unsigned       TIMEOUT        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  output logic              request,
  input  logic              inst_valid,
  input  logic              inst_compressed,
  input  logic [31:0]       inst,
  output logic              flush,
  output logic [CNT_W-1:0]  inst_count,
  output logic              done,
  output logic [1:0]        err
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INSTS);
  localparam int unsigned      RDIV     = (REDIRECT_EVERY == 0) ? 1 : REDIRECT_EVERY;
  localparam logic [CNT_W-1:0] RDIV_W   = CNT_W'(RDIV);
  localparam bit               REDIR_EN = (REDIRECT_EVERY != 0);
  localparam logic [PC_W-1:0]  OFF      = PC_W'(REDIRECT_OFF);

  fetch_state_t     state, state_d;
  logic [PC_W-1:0]  pc_d, pc_seq, pc_red;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic             done_d;
  logic [1:0]       err_d;
  logic             c_bad;
  logic             wd_expired;

  // Upper instruction bits only matter to the optional trace
  logic unused_inst;
  assign unused_inst = ^inst[31:2];

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .enable  (state == RUN),
    .kick    (inst_valid),
    .expired (wd_expired)
  );

  // Next-state, next-pc, retire counter and sticky status
  always_comb begin
    state_d = state;
    pc_d    = pc;
    cnt_d   = inst_count;
    done_d  = done;
    err_d   = err;

    pc_seq  = pc + (inst_compressed ? PC_W'(ILEN_C) : PC_W'(ILEN_N));
    pc_red  = pc_seq + OFF;
    pc_red[0] = 1'b0;
    cnt_inc = (inst_count == '1) ? inst_count : inst_count + CNT_W'(1);
    c_bad   = inst_compressed != (inst[1:0] != 2'b11);

    case (state)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (inst_valid) begin
          if (c_bad) begin
            err_d   = ERR_CMISMATCH;
            state_d = ERROR;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == MAX_CNT) begin
              pc_d    = pc_seq;
              done_d  = 1'b1;
              state_d = DONE;
            end else if (REDIR_EN && ((cnt_inc % RDIV_W) == '0)) begin
              pc_d    = pc_red;
              state_d = REDIRECT;
            end else begin
              pc_d = pc_seq;
            end
          end
        end else if (wd_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ERROR;
        end
      end
      REDIRECT: state_d = RUN;
      DONE:     state_d = DONE;
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_count <= '0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      request    <= 1'b0;
      flush      <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst_count <= cnt_d;
      done       <= done_d;
      err        <= err_d;
      request    <= (state_d == RUN);
      flush      <= (state_d == REDIRECT);
    end
  end

`ifdef FETCH_DRIVER_TRACE_EN
  // Retire / redirect / terminal-state trace
  always @(posedge clk) begin
    if (!rst) begin
      if (state == RUN && inst_valid && !c_bad)
        $display("%t retire inst=%h c=%b pc=%h next=%h count=%0d",
                 $time, inst, inst_compressed, pc, pc_d, cnt_d);
      if (state == RUN && state_d == REDIRECT)
        $display("%t [redirect] target=%h", $time, pc_d);
      if (state != DONE && state_d == DONE)
        $display("%t [done] count=%0d", $time, cnt_d);
      if (state != ERROR && state_d == ERROR)
        $display("%t [error] code=%0d", $time, err_d);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_driver.sv
// Directed, table-driven bench for fetch_driver using three configurations.
module tb_fetch_driver;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] C_NOP = 32'h0000_0001;

  typedef struct {
    logic        valid;
    logic        comp;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [15:0] cnt;
    logic        req;
    logic        flush;
    logic        done;
    logic [1:0]  err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        inst_valid = 1'b0, inst_compressed = 1'b0;
  logic [31:0] inst = 32'h0;

  logic [63:0] pc_a, pc_b, pc_c;
  logic        req_a, req_b, req_c, fl_a, fl_b, fl_c, dn_a, dn_b, dn_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  err_a, err_b, err_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_driver #(.PC_W(64), .RESET_PC(64'h0), .MAX_INSTS(8), .REDIRECT_EVERY(0),
                 .REDIRECT_OFF('h40), .TIMEOUT(64)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .pc(pc_a), .request(req_a),
    .inst_valid(inst_valid), .inst_compressed(inst_compressed), .inst(inst),
    .flush(fl_a), .inst_count(cnt_a), .done(dn_a), .err(err_a));

  fetch_driver #(.PC_W(64), .RESET_PC(64'h0), .MAX_INSTS(256), .REDIRECT_EVERY(4),
                 .REDIRECT_OFF('h40), .TIMEOUT(64)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .pc(pc_b), .request(req_b),
    .inst_valid(inst_valid), .inst_compressed(inst_compressed), .inst(inst),
    .flush(fl_b), .inst_count(cnt_b), .done(dn_b), .err(err_b));

  fetch_driver #(.PC_W(64), .RESET_PC(64'h0), .MAX_INSTS(256), .REDIRECT_EVERY(0),
                 .REDIRECT_OFF('h40), .TIMEOUT(64)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .pc(pc_c), .request(req_c),
    .inst_valid(inst_valid), .inst_compressed(inst_compressed), .inst(inst),
    .flush(fl_c), .inst_count(cnt_c), .done(dn_c), .err(err_c));

  function automatic vec_t mk(input logic v, input logic c, input logic [31:0] i,
                              input logic [63:0] p, input logic [15:0] n,
                              input logic rq, input logic fl, input logic dn,
                              input logic [1:0] e);
    vec_t r;
    r.valid = v; r.comp = c; r.inst = i; r.pc = p; r.cnt = n;
    r.req = rq; r.flush = fl; r.done = dn; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input int d, input string tag, input logic [63:0] p,
                           input logic [15:0] n, input logic rq, input logic fl,
                           input logic dn, input logic [1:0] e);
    logic [63:0] ap; logic [15:0] an; logic arq, afl, adn; logic [1:0] ae;
    case (d)
      0: begin ap = pc_a; an = cnt_a; arq = req_a; afl = fl_a; adn = dn_a; ae = err_a; end
      1: begin ap = pc_b; an = cnt_b; arq = req_b; afl = fl_b; adn = dn_b; ae = err_b; end
      default: begin ap = pc_c; an = cnt_c; arq = req_c; afl = fl_c; adn = dn_c; ae = err_c; end
    endcase
    chk({tag, ".pc"},         ap,        p);
    chk({tag, ".inst_count"}, 64'(an),   64'(n));
    chk({tag, ".request"},    64'(arq),  64'(rq));
    chk({tag, ".flush"},      64'(afl),  64'(fl));
    chk({tag, ".done"},       64'(adn),  64'(dn));
    chk({tag, ".err"},        64'(ae),   64'(e));
  endtask

  task automatic apply(input vec_t v, input int d, input string tag);
    @(negedge clk);
    inst_valid = v.valid; inst_compressed = v.comp; inst = v.inst;
    @(posedge clk); #1;
    check_all(d, tag, v.pc, v.cnt, v.req, v.flush, v.done, v.err);
  endtask

  task automatic run_tbl(input vec_t t[$], input int d, input string tag);
    for (int i = 0; i < t.size(); i++) apply(t[i], d, $sformatf("%s[%0d]", tag, i));
    @(negedge clk);
    inst_valid = 1'b0; inst_compressed = 1'b0; inst = NOP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    inst_valid = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input int d, input string tag);
    @(negedge clk);
    case (d)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    check_all(d, tag, 64'h0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t t1[$], t2[$], t3[$], t4[$], t6[$];

    for (int k = 1; k <= 8; k++)
      t1.push_back(mk(1, 0, NOP, 64'(4 * k), 16'(k), k < 8, 0, k == 8, 0));
    t1.push_back(mk(1, 0, NOP, 64'h20, 16'd8, 0, 0, 1, 0));

    t2.push_back(mk(1, 1, C_NOP, 64'h2, 16'd1, 1, 0, 0, 0));
    t2.push_back(mk(0, 0, NOP,   64'h2, 16'd1, 1, 0, 0, 0));
    t2.push_back(mk(1, 0, NOP,   64'h6, 16'd2, 1, 0, 0, 0));
    t2.push_back(mk(1, 1, C_NOP, 64'h8, 16'd3, 1, 0, 0, 0));
    t2.push_back(mk(1, 0, NOP,   64'hC, 16'd4, 1, 0, 0, 0));

    t3.push_back(mk(1, 0, NOP, 64'h4,  16'd1, 1, 0, 0, 0));
    t3.push_back(mk(1, 0, NOP, 64'h8,  16'd2, 1, 0, 0, 0));
    t3.push_back(mk(1, 0, NOP, 64'hC,  16'd3, 1, 0, 0, 0));
    t3.push_back(mk(1, 0, NOP, 64'h50, 16'd4, 0, 1, 0, 0));
    t3.push_back(mk(1, 1, NOP, 64'h50, 16'd4, 1, 0, 0, 0));  // stale, inconsistent, ignored
    t3.push_back(mk(1, 0, NOP, 64'h54, 16'd5, 1, 0, 0, 0));

    t4.push_back(mk(1, 0, NOP, 64'h4, 16'd1, 1, 0, 0, 0));
    t4.push_back(mk(1, 0, NOP, 64'h8, 16'd2, 1, 0, 0, 0));
    t4.push_back(mk(1, 1, NOP, 64'h8, 16'd2, 0, 0, 0, 2));
    t4.push_back(mk(1, 0, NOP, 64'h8, 16'd2, 0, 0, 0, 2));

    for (int k = 1; k <= 9; k++)
      t6.push_back(mk(1, 0, NOP, 64'(4 * k), 16'(k), 1, 0, 0, 0));

    inst = NOP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_all(0, "reset", 64'h0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Straight-line 4-byte stream to completion
    do_start(0, "t1.start");
    run_tbl(t1, 0, "t1");

    // Mixed 2/4-byte stream
    do_reset();
    do_start(0, "t2.start");
    run_tbl(t2, 0, "t2");

    // Periodic redirect with flush
    do_reset();
    do_start(1, "t3.start");
    run_tbl(t3, 1, "t3");

    // Compressed-flag inconsistency on the 3rd retire
    do_reset();
    do_start(0, "t4.start");
    run_tbl(t4, 0, "t4");

    // Watchdog: 63 stalls are tolerated, the 64th trips it
    do_reset();
    do_start(0, "t5.start");
    repeat (63) @(posedge clk);
    #1 check_all(0, "t5.stall63", 64'h0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1 check_all(0, "t5.stall64", 64'h0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd1);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check_all(0, "t5.start_in_error", 64'h0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd1);

    // Asynchronous reset mid-RUN, then a fresh start
    do_reset();
    do_start(2, "t6.start");
    run_tbl(t6, 2, "t6");
    @(negedge clk); #2 rst = 1'b1;
    #1 check_all(2, "t6.async_rst", 64'h0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk); rst = 1'b0;
    do_start(2, "t6.restart");
    apply(mk(1, 0, NOP, 64'h4, 16'd1, 1, 0, 0, 0), 2, "t6.resume");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
